ddr2_rank_steer: RTL and testbench

- Multi-rank DIMM-side data-path scheduler for the DDR2 simulation environment.
- Snoops the shared command bus, learns CL, AL and BL from MRS/EMRS1 writes, and tracks every READ/WRITE burst in time.
- Each cycle it reports which rank owns DQ/DQS, the bus direction and the per-rank dynamic ODT.
- Flags illegal chip-select use and data-bus collisions; it is the generalised, rank-aware successor to the flat single-rank DIMM wrapper.

---
 rtl/ddr2_pkg.sv | 30 +++
 rtl/ddr2_rank_steer_if.sv | 37 +++
 rtl/ddr2_cmd_decode.sv | 47 ++++
 rtl/ddr2_rank_steer.sv | 170 +++++++++++++++++
 tb/tb_ddr2_rank_steer.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_pkg.sv
// Shared types for the DDR2 rank-aware data-path scheduler: command codes,
// latency limits and the schedule slot layout.
package ddr2_pkg;

    localparam int MIN_CL = 3;
    localparam int MAX_CL = 6;
    localparam int MAX_AL = 5;
    localparam int RANK_W = 2;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_MRS,
        CMD_EMRS1,
        CMD_READ,
        CMD_WRITE,
        CMD_OTHER
    } cmd_t;

    // dir: 1 = write burst, 0 = read burst
    typedef struct packed {
        logic              valid;
        logic              dir;
        logic [RANK_W-1:0] rank;
    } sched_slot_t;

    function automatic logic [3:0] read_lat(input logic [2:0] cl, input logic [2:0] al);
        return {1'b0, cl} + {1'b0, al};
    endfunction

endpackage

// File: rtl/ddr2_rank_steer_if.sv
// Command-bus snoop inputs and per-cycle data-path status of the rank steerer.
// master = command source / status observer, slave = the steerer itself.
interface ddr2_rank_steer_if #(
    parameter int NUM_RANKS = 2
);
    logic                 cke;
    logic [NUM_RANKS-1:0] cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [1:0]           ba;
    logic [14:0]          addr;

    logic                 rd_en;
    logic                 wr_en;
    logic [NUM_RANKS-1:0] bus_rank;
    logic [NUM_RANKS-1:0] odt_rank;
    logic [2:0]           cur_cl;
    logic [2:0]           cur_al;
    logic                 cur_bl8;
    logic                 cs_err;
    logic                 conflict;
    logic [7:0]           err_cnt;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr,
        input  rd_en, wr_en, bus_rank, odt_rank, cur_cl, cur_al, cur_bl8,
               cs_err, conflict, err_cnt
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr,
        output rd_en, wr_en, bus_rank, odt_rank, cur_cl, cur_al, cur_bl8,
               cs_err, conflict, err_cnt
    );

endinterface

// File: rtl/ddr2_cmd_decode.sv
// Pure combinational DDR2 command decoder: strobes/cs_n/ba -> command, rank, multi-select.
// Zero latency; no backpressure (snoops the bus, never stalls it).
module ddr2_cmd_decode
    import ddr2_pkg::*;
#(
    parameter int NUM_RANKS = 2
) (
    input  logic [NUM_RANKS-1:0] i_cs_n,
    input  logic                 i_ras_n,
    input  logic                 i_cas_n,
    input  logic                 i_we_n,
    input  logic [1:0]           i_ba,
    output cmd_t                 o_cmd,
    output logic [RANK_W-1:0]    o_rank,
    output logic                 o_multi
);

    logic [2:0] w_sel_cnt;

    always_comb begin
        w_sel_cnt = '0;
        o_rank    = '0;
        for (int r = NUM_RANKS - 1; r >= 0; r--) begin
            if (!i_cs_n[r]) begin
                w_sel_cnt = w_sel_cnt + 3'd1;
                o_rank    = RANK_W'(r);
            end
        end
        o_multi = (w_sel_cnt > 3'd1);

        o_cmd = CMD_NOP;
        if (w_sel_cnt != 3'd0) begin
            case ({i_ras_n, i_cas_n, i_we_n})
                3'b000: begin
                    if (i_ba == 2'b00)      o_cmd = CMD_MRS;
                    else if (i_ba == 2'b01) o_cmd = CMD_EMRS1;
                    else                    o_cmd = CMD_OTHER;
                end
                3'b101:  o_cmd = CMD_READ;
                3'b100:  o_cmd = CMD_WRITE;
                3'b111:  o_cmd = CMD_NOP;
                default: o_cmd = CMD_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_rank_steer.sv
// Rank-aware DDR2 DQ scheduler: learns CL/AL/BL, steers DQ ownership, direction and ODT.
// Bursts appear RL/WL edges after the command; no backpressure, colliding bursts are dropped.
module ddr2_rank_steer
    import ddr2_pkg::*;
#(
    parameter int NUM_RANKS   = 2,
    parameter int DEF_CL      = 5,
    parameter int DEF_AL      = 0,
    parameter int DEF_BL      = 4,
    parameter int SCHED_DEPTH = 16
) (
    input logic              ck,
    input logic              rst,
    ddr2_rank_steer_if.slave bus
);

    cmd_t              w_cmd;
    logic [RANK_W-1:0] w_rank;
    logic              w_multi;

    ddr2_cmd_decode #(
        .NUM_RANKS (NUM_RANKS)
    ) u_dec (
        .i_cs_n  (bus.cs_n),
        .i_ras_n (bus.ras_n),
        .i_cas_n (bus.cas_n),
        .i_we_n  (bus.we_n),
        .i_ba    (bus.ba),
        .o_cmd   (w_cmd),
        .o_rank  (w_rank),
        .o_multi (w_multi)
    );

    sched_slot_t r_sched [SCHED_DEPTH];
    sched_slot_t w_shift [SCHED_DEPTH];
    sched_slot_t w_nxt   [SCHED_DEPTH];

    logic [2:0]           r_cl;
    logic [2:0]           r_al;
    logic                 r_bl8;
    logic                 r_rd_en;
    logic                 r_wr_en;
    logic [NUM_RANKS-1:0] r_bus_rank;
    logic [NUM_RANKS-1:0] r_odt_rank;
    logic                 r_cs_err;
    logic                 r_conflict;
    logic [7:0]           r_err_cnt;

    logic                 w_live;
    logic                 w_bl_ok;
    logic                 w_cl_ok;
    logic                 w_al_ok;
    logic                 w_mode_err;
    logic                 w_cs_err;
    logic                 w_burst;
    logic                 w_dir;
    logic                 w_hit;
    logic                 w_ins;
    logic                 w_conf;
    int                   w_lat;
    int                   w_dur;
    logic [NUM_RANKS-1:0] w_own;
    logic [NUM_RANKS-1:0] w_odt;
    logic [1:0]           w_err_inc;
    logic [8:0]           w_err_sum;

    // A multi-select is rejected before any field is looked at.
    always_comb begin
        w_live     = bus.cke & ~w_multi;
        w_bl_ok    = (bus.addr[2:0] == 3'b010) || (bus.addr[2:0] == 3'b011);
        w_cl_ok    = (bus.addr[6:4] >= 3'(MIN_CL)) && (bus.addr[6:4] <= 3'(MAX_CL));
        w_al_ok    = (bus.addr[5:3] <= 3'(MAX_AL));
        w_mode_err = w_live & (((w_cmd == CMD_MRS) & ~(w_bl_ok & w_cl_ok)) |
                               ((w_cmd == CMD_EMRS1) & ~w_al_ok));
        w_cs_err   = (bus.cke & w_multi) | w_mode_err;
    end

    // Insert indices are relative to the already-shifted register so that
    // slot k of w_nxt is what the outputs show k edges from now.
    always_comb begin
        w_burst = w_live & ((w_cmd == CMD_READ) | (w_cmd == CMD_WRITE));
        w_dir   = (w_cmd == CMD_WRITE);
        w_lat   = int'(read_lat(r_cl, r_al)) - (w_dir ? 1 : 0);
        w_dur   = r_bl8 ? 4 : 2;

        for (int i = 0; i < SCHED_DEPTH - 1; i++) begin
            w_shift[i] = r_sched[i + 1];
        end
        w_shift[SCHED_DEPTH - 1] = '0;

        w_hit = 1'b0;
        for (int i = 0; i < SCHED_DEPTH; i++) begin
            if (i >= w_lat && i < w_lat + w_dur && w_shift[i].valid) begin
                w_hit = 1'b1;
            end
        end
        w_ins  = w_burst & ~w_hit;
        w_conf = w_burst & w_hit;

        for (int i = 0; i < SCHED_DEPTH; i++) begin
            w_nxt[i] = w_shift[i];
            if (w_ins && i >= w_lat && i < w_lat + w_dur) begin
                w_nxt[i] = '{valid: 1'b1, dir: w_dir, rank: w_rank};
            end
        end
    end

    // Single-rank DIMMs terminate only on writes; multi-rank parks ODT on every non-owner.
    always_comb begin
        for (int r = 0; r < NUM_RANKS; r++) begin
            w_own[r] = w_nxt[0].valid && (w_nxt[0].rank == RANK_W'(r));
        end
        if (!w_nxt[0].valid) begin
            w_odt = '0;
        end else if (NUM_RANKS == 1) begin
            w_odt = {NUM_RANKS{w_nxt[0].dir}};
        end else begin
            w_odt = ~w_own;
        end
    end

    always_comb begin
        w_err_inc = {1'b0, w_cs_err} + {1'b0, w_conf};
        w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_sched    <= '{default: '0};
            r_cl       <= 3'(DEF_CL);
            r_al       <= 3'(DEF_AL);
            r_bl8      <= (DEF_BL == 8);
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_bus_rank <= '0;
            r_odt_rank <= '0;
            r_cs_err   <= 1'b0;
            r_conflict <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_sched    <= w_nxt;
            r_rd_en    <= w_nxt[0].valid & ~w_nxt[0].dir;
            r_wr_en    <= w_nxt[0].valid & w_nxt[0].dir;
            r_bus_rank <= w_own;
            r_odt_rank <= w_odt;
            r_cs_err   <= w_cs_err;
            r_conflict <= w_conf;
            r_err_cnt  <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            if (w_live && w_cmd == CMD_MRS) begin
                if (w_bl_ok) r_bl8 <= bus.addr[0];
                if (w_cl_ok) r_cl  <= bus.addr[6:4];
            end
            if (w_live && w_cmd == CMD_EMRS1 && w_al_ok) begin
                r_al <= bus.addr[5:3];
            end
        end
    end

    assign bus.rd_en    = r_rd_en;
    assign bus.wr_en    = r_wr_en;
    assign bus.bus_rank = r_bus_rank;
    assign bus.odt_rank = r_odt_rank;
    assign bus.cur_cl   = r_cl;
    assign bus.cur_al   = r_al;
    assign bus.cur_bl8  = r_bl8;
    assign bus.cs_err   = r_cs_err;
    assign bus.conflict = r_conflict;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ddr2_rank_steer.sv
// Bench for ddr2_rank_steer: directed scenarios plus random traffic, all checked
// against an absolute-time bus-occupancy model of the DIMM data path.
module tb_ddr2_rank_steer;

    localparam int NR = 2;
    localparam int N  = 1024;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_MRS = 3'b000;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    ddr2_rank_steer_if #(.NUM_RANKS(NR)) bus ();

    ddr2_rank_steer #(
        .NUM_RANKS   (NR),
        .DEF_CL      (5),
        .DEF_AL      (0),
        .DEF_BL      (4),
        .SCHED_DEPTH (16)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: which rank/direction owns DQ after each absolute clock edge.
    bit occ_v [N];
    bit occ_w [N];
    int occ_r [N];
    int m_cl  = 5;
    int m_al  = 0;
    bit m_bl8 = 1'b0;
    int m_err = 0;

    logic [22:0] exp_vec;
    logic [22:0] obs_vec;
    assign obs_vec = {bus.rd_en, bus.wr_en, bus.bus_rank, bus.odt_rank, bus.cur_cl,
                      bus.cur_al, bus.cur_bl8, bus.cs_err, bus.conflict, bus.err_cnt};

    task automatic model_edge(input bit r, input bit ke, input logic [1:0] cs,
                              input logic [2:0] rcw, input logic [1:0] b, input logic [14:0] a);
        int lows, rk, lat, d, idx, f;
        bit cse, cnf, hit, wr;
        logic [1:0] own;
        cse = 1'b0;
        cnf = 1'b0;
        if (r) begin
            for (int i = 0; i < N; i++) occ_v[i] = 1'b0;
            m_cl = 5; m_al = 0; m_bl8 = 1'b0; m_err = 0;
        end else if (ke) begin
            lows = 0;
            rk   = 0;
            for (int i = 0; i < NR; i++) if (cs[i] == 1'b0) begin lows++; rk = i; end
            if (lows > 1) begin
                cse = 1'b1;
            end else if (lows == 1) begin
                if (rcw == C_MRS && b == 2'd0) begin
                    f = int'(a[6:4]);
                    if (a[2:0] == 3'b010)      m_bl8 = 1'b0;
                    else if (a[2:0] == 3'b011) m_bl8 = 1'b1;
                    else                       cse = 1'b1;
                    if (f >= 3 && f <= 6) m_cl = f; else cse = 1'b1;
                end else if (rcw == C_MRS && b == 2'd1) begin
                    f = int'(a[5:3]);
                    if (f <= 5) m_al = f; else cse = 1'b1;
                end else if (rcw == C_RD || rcw == C_WR) begin
                    wr  = (rcw == C_WR);
                    lat = m_cl + m_al - (wr ? 1 : 0);
                    d   = m_bl8 ? 4 : 2;
                    hit = 1'b0;
                    for (int k = 0; k < d; k++) if (occ_v[(cyc + lat + k) % N]) hit = 1'b1;
                    if (hit) begin
                        cnf = 1'b1;
                    end else begin
                        for (int k = 0; k < d; k++) begin
                            idx = (cyc + lat + k) % N;
                            occ_v[idx] = 1'b1;
                            occ_w[idx] = wr;
                            occ_r[idx] = rk;
                        end
                    end
                end
            end
        end
        m_err = m_err + int'(cse) + int'(cnf);
        if (m_err > 255) m_err = 255;
        idx = cyc % N;
        own = occ_v[idx] ? 2'(1 << occ_r[idx]) : 2'b00;
        exp_vec = {occ_v[idx] && !occ_w[idx], occ_v[idx] && occ_w[idx], own,
                   occ_v[idx] ? ~own : 2'b00, 3'(m_cl), 3'(m_al), m_bl8, cse, cnf, 8'(m_err)};
        occ_v[idx] = 1'b0;
        cyc++;
    endtask

    task automatic step(input bit r, input bit ke, input logic [1:0] cs,
                        input logic [2:0] rcw, input logic [1:0] b, input logic [14:0] a);
        @(negedge ck);
        rst = r;
        bus.cke = ke;
        bus.cs_n = cs;
        {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
        bus.ba = b;
        bus.addr = a;
        @(posedge ck);
        model_edge(r, ke, cs, rcw, b, a);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 2'b11, C_NOP, 2'd0, 15'd0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        if (obs_vec !== {2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs_vec,
                               {2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});
        end
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL reset_model got=%h exp=%h", obs_vec, exp_vec);
        end
        checks++;
    endtask

    task automatic test_read_basic();
        logic [4:0] want;
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        idle();
        step(1'b0, 1'b1, 2'b10, C_RD, 2'd0, 15'd0);
        for (int k = 1; k <= 8; k++) begin
            idle();
            want = (k == 5 || k == 6) ? 5'b1_01_10 : 5'b0_00_00;
            if ({bus.rd_en, bus.bus_rank, bus.odt_rank} !== want) begin
                errors++; $display("FAIL read_basic k=%0d got=%b exp=%b", k,
                                   {bus.rd_en, bus.bus_rank, bus.odt_rank}, want);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL read_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_mode_write();
        logic [4:0] want;
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b10, C_MRS, 2'd0, 15'h043);
        step(1'b0, 1'b1, 2'b10, C_MRS, 2'd1, 15'h008);
        if ({bus.cur_cl, bus.cur_al, bus.cur_bl8} !== {3'd4, 3'd1, 1'b1}) begin
            errors++; $display("FAIL mode_regs got=%b exp=%b",
                               {bus.cur_cl, bus.cur_al, bus.cur_bl8}, {3'd4, 3'd1, 1'b1});
        end
        checks++;
        step(1'b0, 1'b1, 2'b01, C_WR, 2'd0, 15'd0);
        for (int k = 1; k <= 9; k++) begin
            idle();
            want = (k >= 4 && k <= 7) ? 5'b1_10_01 : 5'b0_00_00;
            if ({bus.wr_en, bus.bus_rank, bus.odt_rank} !== want) begin
                errors++; $display("FAIL write_bl8 k=%0d got=%b exp=%b", k,
                                   {bus.wr_en, bus.bus_rank, bus.odt_rank}, want);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL write_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] want;
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b10, C_RD, 2'd0, 15'd0);
        for (int j = 1; j <= 10; j++) begin
            if (j == 2) step(1'b0, 1'b1, 2'b01, C_RD, 2'd0, 15'd0);
            else        idle();
            want = (j == 5 || j == 6) ? 3'b01_0 : (j == 7 || j == 8) ? 3'b10_0 : 3'b00_0;
            if ({bus.bus_rank, bus.conflict} !== want) begin
                errors++; $display("FAIL seamless j=%0d got=%b exp=%b", j,
                                   {bus.bus_rank, bus.conflict}, want);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL seamless_model j=%0d got=%h exp=%h", j, obs_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b10, C_RD, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b01, C_WR, 2'd0, 15'd0);
        if ({bus.conflict, bus.err_cnt} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL collision_pulse got=%b/%0d exp=1/1", bus.conflict, bus.err_cnt);
        end
        checks++;
        for (int j = 2; j <= 10; j++) begin
            idle();
            if ({bus.wr_en, bus.conflict} !== 2'b00) begin
                errors++; $display("FAIL collision_drop j=%0d wr_en=%b conflict=%b exp=0/0",
                                   j, bus.wr_en, bus.conflict);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL collision_model j=%0d got=%h exp=%h", j, obs_vec, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_cs_err();
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b00, C_RD, 2'd0, 15'd0);
        if ({bus.cs_err, bus.err_cnt} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL multi_select got=%b/%0d exp=1/1", bus.cs_err, bus.err_cnt);
        end
        checks++;
        for (int k = 1; k <= 8; k++) begin
            idle();
            if ({bus.rd_en, bus.bus_rank, bus.cs_err} !== 4'b0) begin
                errors++; $display("FAIL multi_ignored k=%0d got=%b exp=0000", k,
                                   {bus.rd_en, bus.bus_rank, bus.cs_err});
            end
            checks++;
        end
        step(1'b0, 1'b1, 2'b10, C_MRS, 2'd0, 15'h072);
        if ({bus.cs_err, bus.cur_cl, bus.err_cnt} !== {1'b1, 3'd5, 8'd2}) begin
            errors++; $display("FAIL bad_cl got=%b/%0d/%0d exp=1/5/2",
                               bus.cs_err, bus.cur_cl, bus.err_cnt);
        end
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL bad_cl_model got=%h exp=%h", obs_vec, exp_vec);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        step(1'b0, 1'b1, 2'b10, C_MRS, 2'd0, 15'h053);
        step(1'b0, 1'b1, 2'b10, C_RD, 2'd0, 15'd0);
        for (int k = 1; k <= 6; k++) idle();
        if (bus.rd_en !== 1'b1) begin
            errors++; $display("FAIL bl8_active rd_en=%b exp=1", bus.rd_en);
        end
        checks++;
        step(1'b1, 1'b1, 2'b11, C_NOP, 2'd0, 15'd0);
        if (obs_vec !== {2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL mid_reset got=%h exp=%h", obs_vec,
                               {2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});
        end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            idle();
            if (bus.rd_en !== 1'b0) begin
                errors++; $display("FAIL mid_reset_abort k=%0d rd_en=%b exp=0", k, bus.rd_en);
            end
            checks++;
        end
        step(1'b0, 1'b1, 2'b01, C_RD, 2'd0, 15'd0);
        for (int k = 1; k <= 5; k++) idle();
        if ({bus.rd_en, bus.bus_rank} !== 3'b1_10) begin
            errors++; $display("FAIL post_reset_read got=%b exp=110", {bus.rd_en, bus.bus_rank});
        end
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL post_reset_model got=%h exp=%h", obs_vec, exp_vec);
        end
        checks++;
    endtask

    task automatic test_err_sat();
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        for (int k = 0; k < 260; k++) step(1'b0, 1'b1, 2'b00, C_NOP, 2'd0, 15'd0);
        if ({bus.cs_err, bus.err_cnt} !== {1'b1, 8'd255}) begin
            errors++; $display("FAIL err_saturate got=%b/%0d exp=1/255", bus.cs_err, bus.err_cnt);
        end
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL err_saturate_model got=%h exp=%h", obs_vec, exp_vec);
        end
        checks++;
    endtask

    task automatic test_random();
        bit r, ke;
        int sel, kind;
        logic [1:0] cs, b;
        logic [2:0] rcw;
        logic [14:0] a;
        step(1'b1, 1'b0, 2'b11, C_NOP, 2'd0, 15'd0);
        for (int n = 0; n < 800; n++) begin
            r    = ($urandom_range(0, 149) == 0);
            ke   = ($urandom_range(0, 9) != 0);
            sel  = $urandom_range(0, 9);
            cs   = (sel < 4) ? 2'b10 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b00 : 2'b11;
            kind = $urandom_range(0, 11);
            a    = 15'($urandom);
            b    = 2'd0;
            if (kind < 4)       rcw = C_RD;
            else if (kind < 7)  rcw = C_WR;
            else if (kind < 10) rcw = C_MRS;
            else if (kind == 10) rcw = 3'($urandom);
            else                rcw = C_NOP;
            if (rcw == C_MRS) begin
                b = 2'($urandom_range(0, 2));
                if (b == 2'd1) begin
                    a[5:3] = 3'($urandom_range(0, 6));
                end else if ($urandom_range(0, 3) != 0) begin
                    a[2:0] = {2'b01, 1'($urandom)};
                    a[6:4] = 3'($urandom_range(3, 6));
                end
            end
            step(r, ke, cs, rcw, b, a);
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random n=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cke = 1'b0;
        bus.cs_n = 2'b11;
        {bus.ras_n, bus.cas_n, bus.we_n} = C_NOP;
        bus.ba = 2'd0;
        bus.addr = 15'd0;
        test_reset();
        test_read_basic();
        test_mode_write();
        test_back_to_back();
        test_collision();
        test_cs_err();
        test_reset_mid();
        test_err_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
